mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Owner encoding is chosen so the reset value of the last-owner flag gives data first priority.
package mem_arbiter_pkg;

  localparam int DEFAULT_DATA_SIZE    = 32;
  localparam int DEFAULT_ADDRESS_SIZE = 16;
  localparam int WAIT_CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store requesters.
// Optional macro MEM_ARBITER_ROUND_ROBIN_EN alternates the winner of simultaneous requests.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_SIZE    = DEFAULT_DATA_SIZE,
  parameter int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE,
  parameter int WAIT_CYCLES  = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    fetch_req,
  input  logic [ADDRESS_SIZE-1:0] fetch_address,
  output logic                    fetch_ready,
  output logic [DATA_SIZE-1:0]    fetch_data,
  input  logic                    data_req,
  input  logic                    data_read_write,
  input  logic [ADDRESS_SIZE-1:0] data_address,
  input  logic [DATA_SIZE-1:0]    data_wdata,
  output logic                    data_ready,
  output logic [DATA_SIZE-1:0]    data_rdata,
  output logic                    ram_enable,
  output logic                    ram_read_write,
  output logic [ADDRESS_SIZE-1:0] ram_address,
  output logic [DATA_SIZE-1:0]    ram_data_out,
  input  logic [DATA_SIZE-1:0]    ram_data_in,
  output logic                    busy
);

  arb_state_e              state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  owner_e                  owner_q, owner_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic                    rw_q, rw_d;
  logic [DATA_SIZE-1:0]    wdata_q, wdata_d;
  logic [DATA_SIZE-1:0]    fetch_data_q, fetch_data_d;
  logic [DATA_SIZE-1:0]    data_rdata_q, data_rdata_d;
  logic                    fetch_ready_q, fetch_ready_d;
  logic                    data_ready_q, data_ready_d;
  logic                    ram_enable_q, ram_enable_d;
  logic                    busy_q, busy_d;
  logic                    grant_data_s;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  owner_e                  last_owner_q, last_owner_d;

  // Winner selection: on a conflict the side that lost the previous conflict wins.
  always_comb begin
    grant_data_s = data_req;
    last_owner_d = last_owner_q;
    if ((state_q == ST_IDLE) && fetch_req && data_req) begin
      grant_data_s = (last_owner_q == OWNER_FETCH);
      last_owner_d = (last_owner_q == OWNER_FETCH) ? OWNER_DATA : OWNER_FETCH;
    end else begin
      grant_data_s = data_req;
    end
  end

  // Conflict history register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_owner_q <= OWNER_FETCH;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  // Winner selection: data has fixed priority over fetch.
  always_comb begin
    grant_data_s = data_req;
  end
`endif

  // Next-state, latching and capture logic; registered outputs follow the next state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    wdata_d      = wdata_q;
    fetch_data_d = fetch_data_q;
    data_rdata_d = data_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (fetch_req || data_req) begin
          state_d = ST_ACCESS;
          cnt_d   = WAIT_CNT_W'(WAIT_CYCLES);
          if (grant_data_s) begin
            owner_d = OWNER_DATA;
            addr_d  = data_address;
            rw_d    = data_read_write;
            wdata_d = data_wdata;
          end else begin
            owner_d = OWNER_FETCH;
            addr_d  = fetch_address;
            rw_d    = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == {WAIT_CNT_W{1'b0}}) begin
          state_d = ST_RESP;
          if (owner_q == OWNER_FETCH) begin
            fetch_data_d = ram_data_in;
          end else if (rw_q) begin
            data_rdata_d = ram_data_in;
          end else begin
            data_rdata_d = data_rdata_q;
          end
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ram_enable_d  = (state_d == ST_ACCESS);
    busy_d        = (state_d != ST_IDLE);
    fetch_ready_d = (state_d == ST_RESP) && (owner_d == OWNER_FETCH);
    data_ready_d  = (state_d == ST_RESP) && (owner_d == OWNER_DATA);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= {WAIT_CNT_W{1'b0}};
      owner_q       <= OWNER_FETCH;
      addr_q        <= {ADDRESS_SIZE{1'b0}};
      rw_q          <= 1'b1;
      wdata_q       <= {DATA_SIZE{1'b0}};
      fetch_data_q  <= {DATA_SIZE{1'b0}};
      data_rdata_q  <= {DATA_SIZE{1'b0}};
      fetch_ready_q <= 1'b0;
      data_ready_q  <= 1'b0;
      ram_enable_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
      addr_q        <= addr_d;
      rw_q          <= rw_d;
      wdata_q       <= wdata_d;
      fetch_data_q  <= fetch_data_d;
      data_rdata_q  <= data_rdata_d;
      fetch_ready_q <= fetch_ready_d;
      data_ready_q  <= data_ready_d;
      ram_enable_q  <= ram_enable_d;
      busy_q        <= busy_d;
    end
  end

  assign fetch_ready    = fetch_ready_q;
  assign fetch_data     = fetch_data_q;
  assign data_ready     = data_ready_q;
  assign data_rdata     = data_rdata_q;
  assign ram_enable     = ram_enable_q;
  assign ram_read_write = rw_q;
  assign ram_address    = addr_q;
  assign ram_data_out   = wdata_q;
  assign busy           = busy_q;

endmodule
